// File: rtl/pipe_stage_hs_pkg.sv
// Shared types for the handshake pipeline stage: state encoding, default widths
// and the state-to-occupancy decode.
package pipe_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} pipe_state_t;

  localparam int DEF_CNT_W = 16;
  localparam int OCC_W     = 2;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    case (s)
      ST_BUSY: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (inc && (cnt_q != {W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage register with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build (registered in_ready).
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                CNT_W   = DEF_CNT_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              accept, emit;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;

  // Decoded from registered state only, so no out_ready->in_ready path.
  assign in_ready = (state_q != ST_FULL) && !rst;
`else
  assign in_ready = (!out_valid || out_ready) && !rst;
`endif

  // NOTE: every variable written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
`endif
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (emit) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // NOTE: the skid data register is cleared on reset so a stale payload can
  // never surface before the first real write.
  always_ff @(posedge clk) begin
    if (rst) skid_q <= RST_VAL;
    else     skid_q <= skid_d;
  end
`endif

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Scoreboard bench for pipe_stage_hs; expected in_ready/occupancy follow the
// PIPE_STAGE_SKID_EN setting. A second instance with CNT_W=4 covers saturation.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  logic [31:0] sb[$];
  int          stall_m, sat_m, n_emit;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_hs dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_hs #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  // One clock cycle: drive inputs at negedge, compare against the model,
  // then update the model on the posedge.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic fl, output logic acc);
    int   sz;
    logic exp_valid, exp_ready;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    sz        = sb.size();
    exp_valid = (sz > 0);
`ifdef PIPE_STAGE_SKID_EN
    exp_ready = (sz < 2);
`else
    exp_ready = (sz == 0) || ordy;
`endif
    n_cmp++;
    if (out_valid !== exp_valid) begin
      n_err++; $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_valid);
    end
    n_cmp++;
    if (in_ready !== exp_ready) begin
      n_err++; $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
    end
    n_cmp++;
    if (occupancy !== 2'(sz)) begin
      n_err++; $display("FAIL occupancy @%0t: got %0d expected %0d", $time, occupancy, sz);
    end
    n_cmp++;
    if (stall_cnt !== 16'(stall_m)) begin
      n_err++; $display("FAIL stall_cnt @%0t: got %0d expected %0d", $time, stall_cnt, stall_m);
    end
    n_cmp++;
    if (s_stall_cnt !== 4'(sat_m)) begin
      n_err++; $display("FAIL stall_cnt_sat @%0t: got %0d expected %0d", $time, s_stall_cnt, sat_m);
    end
    if (exp_valid) begin
      n_cmp++;
      if (out_data !== sb[0]) begin
        n_err++; $display("FAIL out_data @%0t: got %h expected %h", $time, out_data, sb[0]);
      end
    end
    acc = iv && exp_ready && !fl;
    @(posedge clk);
    if (exp_valid && !ordy) begin
      stall_m++;
      if (sat_m < 15) sat_m++;
    end
    if (fl) sb.delete();
    else begin
      if (exp_valid && ordy) begin
        void'(sb.pop_front());
        n_emit++;
      end
      if (acc) sb.push_back(id);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete(); stall_m = 0; sat_m = 0; n_emit = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; flush = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || stall_cnt !== 16'h0 || occupancy !== 2'd0) begin
        n_err++;
        $display("FAIL reset_state: got valid=%b data=%h stall=%0d occ=%0d expected 0/0/0/0",
                 out_valid, out_data, stall_cnt, occupancy);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
    end
    sb.delete(); stall_m = 0; sat_m = 0; n_emit = 0;
  endtask

  task automatic test_streaming();
    logic acc;
    apply_reset();
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, 32'(i), 1'b1, 1'b0, acc);
      n_cmp++;
      if (acc !== 1'b1 || n_emit !== i - 1) begin
        n_err++; $display("FAIL stream_rate i=%0d: got acc=%b emitted=%0d expected 1/%0d", i, acc, n_emit, i - 1);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    n_cmp++;
    if (n_emit !== 100 || stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL stream_total: got emitted=%0d stall=%0d expected 100/0", n_emit, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] items[3];
    logic        acc;
    int          idx, exp_occ;
    items[0] = 32'hA; items[1] = 32'hB; items[2] = 32'hC;
    apply_reset();
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, items[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
`ifdef PIPE_STAGE_SKID_EN
    exp_occ = 2;
`else
    exp_occ = 1;
`endif
    #1;
    n_cmp++;
    if (occupancy !== 2'(exp_occ) || in_ready !== 1'b0 || idx !== exp_occ) begin
      n_err++;
      $display("FAIL bp_hold: got occ=%0d in_ready=%b accepted=%0d expected %0d/0/%0d",
               occupancy, in_ready, idx, exp_occ, exp_occ);
    end
    n_cmp++;
    if (stall_cnt !== 16'd3) begin
      n_err++; $display("FAIL bp_stall: got %0d expected 3", stall_cnt);
    end
    for (int c = 0; c < 10; c++) begin
      if (idx < 3) begin
        cycle(1'b1, items[idx], 1'b1, 1'b0, acc);
        if (acc) idx++;
      end else begin
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
      end
    end
    n_cmp++;
    if (n_emit !== 3 || idx !== 3) begin
      n_err++; $display("FAIL bp_drain: got emitted=%0d accepted=%0d expected 3/3", n_emit, idx);
    end
  endtask

  task automatic test_flush();
    logic acc;
    apply_reset();
    cycle(1'b1, 32'h11, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h7, 1'b0, 1'b1, acc);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      n_err++;
      $display("FAIL flush_state: got valid=%b occ=%0d data=%h expected 0/0/0", out_valid, occupancy, out_data);
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    n_cmp++;
    if (n_emit !== 0) begin
      n_err++; $display("FAIL flush_no_emit: got %0d emitted expected 0", n_emit);
    end
  endtask

  task automatic test_saturation();
    logic acc;
    apply_reset();
    cycle(1'b1, 32'h5A, 1'b0, 1'b0, acc);
    for (int c = 0; c < 20; c++) cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
    #1;
    n_cmp++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
      n_err++; $display("FAIL saturation: got sat=%0d wide=%0d expected 15/20", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic        acc, iv, ordy, fl;
    logic [31:0] d;
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 199) == 0);
      d    = iv ? $urandom : 32'hxxxx_xxxx;
      cycle(iv, d, ordy, fl, acc);
    end
    for (int c = 0; c < 4; c++) cycle(1'b0, 32'hxxxx_xxxx, 1'b1, 1'b0, acc);
    #1;
    n_cmp++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL random_drain: got occ=%0d valid=%b expected 0/0", occupancy, out_valid);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
